// File: rtl/approx_rca_if.sv
// Operand/result handshake bundle for the pipelined approximate adder.
// The master drives operands and out_ready. The slave (the adder) returns
// in_ready, out_valid and the sum.
interface approx_rca_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] IN1;
    logic [WIDTH-1:0] IN2;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   Out;

    modport master (
        output in_valid, IN1, IN2, mode, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, IN1, IN2, mode, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/approx_rca_pipe.sv
// Pipelined approximate ripple-carry adder with an online error monitor.
// The carry chain is cut into STAGES segments of ceil(WIDTH/STAGES) bits.
// Each bank is an elastic stage: it loads when it is empty or when its
// contents move on in the same cycle. The exact sum is computed at capture
// and travels with the beat, so the monitor can compare at the output.
module approx_rca_pipe #(
    parameter int WIDTH  = 8,
    parameter int APPROX = 4,
    parameter int STAGES = 2,
    parameter int ACC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    approx_rca_if.slave      bus,
    input  logic             stat_clear,
    output logic [ACC_W-1:0] samples,
    output logic [ACC_W-1:0] err_count,
    output logic [ACC_W-1:0] sq_err_sum,
    output logic [WIDTH+1:0] max_abs_err
);
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             m;
        logic [WIDTH:0]   ex;
    } stg_t;

    stg_t cap;

    // Beat as captured: operands, mode and the exact reference sum.
    always_comb begin
        cap    = '0;
        cap.a  = bus.IN1;
        cap.b  = bus.IN2;
        cap.m  = bus.mode;
        cap.ex = {1'b0, bus.IN1} + {1'b0, bus.IN2};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // A late segment can be empty when STAGES does not divide WIDTH evenly.
        localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
        localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;

        stg_t src, nx, q;
        logic src_v, v, ld, av, z;

        if (k == 0) begin : g_head
            assign src   = cap;
            assign src_v = bus.in_valid;
        end else begin : g_body
            assign src   = g_stg[k-1].q;
            assign src_v = g_stg[k-1].v;
        end

        if (k == STAGES - 1) begin : g_tail
            assign av = v & bus.out_ready;
        end else begin : g_link
            assign av = v & g_stg[k+1].ld;
        end

        assign ld = ~v | av;

        // Ripple this segment from the carry left by the previous stage.
        always_comb begin
            nx = src;
            z  = 1'b0;
            for (int i = LO; i < HI; i++) begin
                z = nx.c;
                if (i < APPROX && src.m) begin
                    nx.s[i] = src.b[i] & (src.a[i] | z);
                    nx.c    = src.a[i] | ~src.b[i];
                end else begin
                    nx.s[i] = src.a[i] ^ src.b[i] ^ z;
                    nx.c    = (src.a[i] & src.b[i]) | (z & (src.a[i] ^ src.b[i]));
                end
            end
        end

        // Stage bank: a load with no incoming beat empties the stage.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                q <= '0;
            end else if (ld) begin
                v <= src_v;
                if (src_v) q <= nx;
            end
        end
    end

    stg_t             last;
    logic             hs;
    logic             unused_last;
    logic [WIDTH+1:0] e;
    logic [WIDTH+1:0] abs_e;
    logic [ACC_W:0]   sq;

    assign last          = g_stg[STAGES-1].q;
    assign bus.out_valid = g_stg[STAGES-1].v;
    assign bus.Out       = {last.c, last.s};
    assign bus.in_ready  = ~rst & g_stg[0].ld;
    assign hs            = bus.out_valid & bus.out_ready;
    assign unused_last   = ^{last.a, last.b, last.m};

    // Signed error of the presented result against the exact sum.
    // Both values are below 2^(WIDTH+1), so WIDTH+2 bits cannot overflow.
    always_comb begin
        e     = {1'b0, last.c, last.s} - {1'b0, last.ex};
        abs_e = e[WIDTH+1] ? -e : e;
        sq    = (ACC_W+1)'(abs_e) * (ACC_W+1)'(abs_e);
    end

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W:0]   inc);
        logic [ACC_W+1:0] s;
        s = {2'b00, acc} + {1'b0, inc};
        return (s[ACC_W+1:ACC_W] != 2'b00) ? '1 : s[ACC_W-1:0];
    endfunction

    // Statistics: a clear takes priority over a coincident handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples     <= '0;
            err_count   <= '0;
            sq_err_sum  <= '0;
            max_abs_err <= '0;
        end else if (stat_clear) begin
            samples     <= '0;
            err_count   <= '0;
            sq_err_sum  <= '0;
            max_abs_err <= '0;
        end else if (hs) begin
            samples    <= sat_add(samples, (ACC_W+1)'(1));
            err_count  <= sat_add(err_count, (ACC_W+1)'(e != '0));
            sq_err_sum <= sat_add(sq_err_sum, sq);
            if (abs_e > max_abs_err) max_abs_err <= abs_e;
        end
    end
endmodule
